ysyx_23060025_wbu_stage: RTL and testbench

Final pipeline stage, directly downstream of the load/store stage. Holds one instruction, retires it by driving the GPR write port, and commits CSR side effects into a local machine-mode CSR file. It also feeds a write-back forwarding path to decode and halts the core when ebreak retires.

---
 rtl/ysyx_23060025_wbu_stage.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_23060025_wbu_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_wbu_stage.sv
// Write-back stage: holds one instruction, retires it to the GPR file,
// commits CSR side effects into a local M-mode CSR file, and halts on ebreak.
module ysyx_23060025_wbu_stage #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lsu_to_wbu_valid_i,
  output logic                wbu_allowin_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic [2:0]          csr_type_i,
  input  logic [11:0]         csr_waddr_i,
  input  logic [DATA_LEN-1:0] csr_mcause_i,
  input  logic                ebreak_flag_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                rf_we_o,
  output logic [4:0]          rf_waddr_o,
  output logic [DATA_LEN-1:0] rf_wdata_o,
  output logic                ws_fwd_valid_o,
  output logic [4:0]          ws_fwd_reg_o,
  output logic [DATA_LEN-1:0] ws_fwd_data_o,
  output logic                ws_csr_fwd_valid_o,
  output logic [11:0]         ws_csr_fwd_addr_o,
  output logic [DATA_LEN-1:0] ws_csr_fwd_data_o,
  input  logic [11:0]         csr_raddr_i,
  output logic [DATA_LEN-1:0] csr_rdata_o,
  output logic [DATA_LEN-1:0] mtvec_o,
  output logic [ADDR_LEN-1:0] mepc_o,
  output logic                retire_o,
  output logic [ADDR_LEN-1:0] retire_pc_o,
  output logic                halt_o
);

  localparam logic [2:0] CSR_CSRRW = 3'd1;
  localparam logic [2:0] CSR_CSRRS = 3'd2;
  localparam logic [2:0] CSR_ECALL = 3'd3;

  typedef enum logic {RUN, HALT} state_t;

  state_t                state_reg, state_next;
  logic                  valid_reg;
  logic                  wd_reg;
  logic [4:0]            wreg_reg;
  logic [DATA_LEN-1:0]   wdata_reg;
  logic [DATA_LEN-1:0]   csr_wdata_reg;
  logic [2:0]            csr_type_reg;
  logic [11:0]           csr_waddr_reg;
  logic [DATA_LEN-1:0]   csr_mcause_reg;
  logic                  ebreak_reg;
  logic [ADDR_LEN-1:0]   pc_reg;

  logic [DATA_LEN-1:0]   mstatus_reg, mtvec_reg, mcause_reg;
  logic [ADDR_LEN-1:0]   mepc_reg;
  logic [2*DATA_LEN-1:0] mcycle_reg, mcycle_next;
  logic [2*DATA_LEN-1:0] minstret_reg, minstret_next;

  logic retire;
  logic capture;
  logic csr_we;
  logic gpr_wr;

  // In RUN the stage always completes in one cycle, so it only blocks when halted.
  assign wbu_allowin_o = (state_reg == RUN);
  assign capture       = lsu_to_wbu_valid_i && wbu_allowin_o;
  assign retire        = valid_reg && (state_reg == RUN);
  assign gpr_wr        = wd_reg && (wreg_reg != 5'd0);
  assign csr_we        = retire && ((csr_type_reg == CSR_CSRRW) || (csr_type_reg == CSR_CSRRS));

  assign rf_we_o            = retire && gpr_wr;
  assign rf_waddr_o         = wreg_reg;
  assign rf_wdata_o         = wdata_reg;
  assign ws_fwd_valid_o     = valid_reg && gpr_wr;
  assign ws_fwd_reg_o       = wreg_reg;
  assign ws_fwd_data_o      = wdata_reg;
  assign ws_csr_fwd_valid_o = valid_reg && ((csr_type_reg == CSR_CSRRW) || (csr_type_reg == CSR_CSRRS));
  assign ws_csr_fwd_addr_o  = csr_waddr_reg;
  assign ws_csr_fwd_data_o  = csr_wdata_reg;
  assign retire_o           = retire;
  assign retire_pc_o        = pc_reg;
  assign mtvec_o            = mtvec_reg;
  assign mepc_o             = mepc_reg;

  // State register; HALT is only left through reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // Next state and halt flag: ebreak retiring moves the core to HALT.
  always_comb begin
    state_next = state_reg;
    halt_o     = 1'b0;
    case (state_reg)
      RUN:     if (retire && ebreak_reg) state_next = HALT;
      HALT:    halt_o = 1'b1;
      default: state_next = RUN;
    endcase
  end

  // Valid bit and payload capture; a retiring ebreak kills any same-edge capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_reg      <= 1'b0;
      wd_reg         <= 1'b0;
      wreg_reg       <= '0;
      wdata_reg      <= '0;
      csr_wdata_reg  <= '0;
      csr_type_reg   <= '0;
      csr_waddr_reg  <= '0;
      csr_mcause_reg <= '0;
      ebreak_reg     <= 1'b0;
      pc_reg         <= '0;
    end else begin
      if (retire && ebreak_reg) valid_reg <= 1'b0;
      else if (capture)         valid_reg <= 1'b1;
      else if (retire)          valid_reg <= 1'b0;
      if (capture && !(retire && ebreak_reg)) begin
        wd_reg         <= wd_i;
        wreg_reg       <= wreg_i;
        wdata_reg      <= wdata_i;
        csr_wdata_reg  <= csr_wdata_i;
        csr_type_reg   <= csr_type_i;
        csr_waddr_reg  <= csr_waddr_i;
        csr_mcause_reg <= csr_mcause_i;
        ebreak_reg     <= ebreak_flag_i;
        pc_reg         <= pc_i;
      end
    end
  end

  // Counter next values: increment with full 64-bit carry, then let a CSR write to either half override it.
  always_comb begin
    mcycle_next   = mcycle_reg;
    minstret_next = minstret_reg;
    if (state_reg == RUN) mcycle_next   = mcycle_reg + 1'b1;
    if (retire)           minstret_next = minstret_reg + 1'b1;
    if (csr_we) begin
      case (csr_waddr_reg)
        12'hB00: mcycle_next[DATA_LEN-1:0]            = csr_wdata_reg;
        12'hB80: mcycle_next[2*DATA_LEN-1:DATA_LEN]   = csr_wdata_reg;
        12'hB02: minstret_next[DATA_LEN-1:0]          = csr_wdata_reg;
        12'hB82: minstret_next[2*DATA_LEN-1:DATA_LEN] = csr_wdata_reg;
        default: ;
      endcase
    end
  end

  // CSR file commit at the retire edge; read-only and unknown addresses are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus_reg  <= 32'h0000_1800;
      mtvec_reg    <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mcycle_reg   <= '0;
      minstret_reg <= '0;
    end else begin
      mcycle_reg   <= mcycle_next;
      minstret_reg <= minstret_next;
      if (csr_we) begin
        case (csr_waddr_reg)
          12'h300: mstatus_reg <= csr_wdata_reg;
          12'h305: mtvec_reg   <= csr_wdata_reg;
          12'h341: mepc_reg    <= csr_wdata_reg;
          12'h342: mcause_reg  <= csr_wdata_reg;
          default: ;
        endcase
      end else if (retire && (csr_type_reg == CSR_ECALL)) begin
        mepc_reg   <= pc_reg;
        mcause_reg <= csr_mcause_reg;
      end
    end
  end

  // Combinational CSR read port for decode.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      12'h300: csr_rdata_o = mstatus_reg;
      12'h305: csr_rdata_o = mtvec_reg;
      12'h341: csr_rdata_o = mepc_reg;
      12'h342: csr_rdata_o = mcause_reg;
      12'hB00: csr_rdata_o = mcycle_reg[DATA_LEN-1:0];
      12'hB80: csr_rdata_o = mcycle_reg[2*DATA_LEN-1:DATA_LEN];
      12'hB02: csr_rdata_o = minstret_reg[DATA_LEN-1:0];
      12'hB82: csr_rdata_o = minstret_reg[2*DATA_LEN-1:DATA_LEN];
      12'hF11: csr_rdata_o = 32'h7973_7978;
      12'hF12: csr_rdata_o = 32'h015F_DE39;
      default: csr_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_wbu_stage.sv
// Directed bench for the write-back stage: reset values, GPR retire, CSR
// commits, counter wrap/priority, ebreak halt and asynchronous reset.
module tb_ysyx_23060025_wbu_stage;

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_CSRRW = 3'd1;
  localparam logic [2:0] T_ECALL = 3'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsu_to_wbu_valid_i;
  logic        wbu_allowin_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] csr_wdata_i;
  logic [2:0]  csr_type_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_mcause_i;
  logic        ebreak_flag_i;
  logic [31:0] pc_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        ws_fwd_valid_o;
  logic [4:0]  ws_fwd_reg_o;
  logic [31:0] ws_fwd_data_o;
  logic        ws_csr_fwd_valid_o;
  logic [11:0] ws_csr_fwd_addr_o;
  logic [31:0] ws_csr_fwd_data_o;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        retire_o;
  logic [31:0] retire_pc_o;
  logic        halt_o;

  int errors = 0;
  int checks = 0;

  ysyx_23060025_wbu_stage dut (
    .clock(clock), .reset(reset),
    .lsu_to_wbu_valid_i(lsu_to_wbu_valid_i), .wbu_allowin_o(wbu_allowin_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .csr_wdata_i(csr_wdata_i), .csr_type_i(csr_type_i), .csr_waddr_i(csr_waddr_i),
    .csr_mcause_i(csr_mcause_i), .ebreak_flag_i(ebreak_flag_i), .pc_i(pc_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .ws_fwd_valid_o(ws_fwd_valid_o), .ws_fwd_reg_o(ws_fwd_reg_o), .ws_fwd_data_o(ws_fwd_data_o),
    .ws_csr_fwd_valid_o(ws_csr_fwd_valid_o), .ws_csr_fwd_addr_o(ws_csr_fwd_addr_o),
    .ws_csr_fwd_data_o(ws_csr_fwd_data_o),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .retire_o(retire_o), .retire_pc_o(retire_pc_o), .halt_o(halt_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Read a CSR through the combinational port and compare.
  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_raddr_i = addr;
    #1;
    check(tag, csr_rdata_o, exp);
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                      input logic [2:0] ctype, input logic [11:0] caddr, input logic [31:0] cdata,
                      input logic [31:0] mcause, input logic ebreak, input logic [31:0] pc);
    lsu_to_wbu_valid_i = 1'b1;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    csr_type_i = ctype; csr_waddr_i = caddr; csr_wdata_i = cdata;
    csr_mcause_i = mcause; ebreak_flag_i = ebreak; pc_i = pc;
  endtask

  task automatic idle();
    lsu_to_wbu_valid_i = 1'b0;
    wd_i = 1'b0; ebreak_flag_i = 1'b0; csr_type_i = T_NONE;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wreg_i = 0; wdata_i = 0; csr_waddr_i = 0; csr_wdata_i = 0; csr_mcause_i = 0; pc_i = 0;
    csr_raddr_i = 0;

    // Reset values
    repeat (3) tick();
    reset = 1'b0;
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_marchid", 12'hF12, 32'h015F_DE39);
    rd("rst_mvendorid", 12'hF11, 32'h7973_7978);
    rd("rst_mepc", 12'h341, 32'h0);
    check("rst_allowin", {31'b0, wbu_allowin_o}, 32'd1);
    check("rst_halt", {31'b0, halt_o}, 32'd0);
    check("rst_retire", {31'b0, retire_o}, 32'd0);

    // Back-to-back GPR writes, x0 suppressed
    send(1, 5'd5, 32'h11, T_NONE, 0, 0, 0, 0, 32'h8000_0000);
    tick();
    check("b2b1_we", {31'b0, rf_we_o}, 32'd1);
    check("b2b1_addr", {27'b0, rf_waddr_o}, 32'd5);
    check("b2b1_data", rf_wdata_o, 32'h11);
    check("b2b1_fwd", {31'b0, ws_fwd_valid_o}, 32'd1);
    check("b2b1_pc", retire_pc_o, 32'h8000_0000);
    send(1, 5'd0, 32'h22, T_NONE, 0, 0, 0, 0, 32'h8000_0004);
    tick();
    check("b2b2_we_x0", {31'b0, rf_we_o}, 32'd0);
    check("b2b2_retire", {31'b0, retire_o}, 32'd1);
    check("b2b2_fwd_x0", {31'b0, ws_fwd_valid_o}, 32'd0);
    send(1, 5'd6, 32'h33, T_NONE, 0, 0, 0, 0, 32'h8000_0008);
    tick();
    check("b2b3_we", {31'b0, rf_we_o}, 32'd1);
    check("b2b3_addr", {27'b0, rf_waddr_o}, 32'd6);
    check("b2b3_data", rf_wdata_o, 32'h33);
    idle();
    tick();
    check("b2b_idle_we", {31'b0, rf_we_o}, 32'd0);
    check("b2b_idle_retire", {31'b0, retire_o}, 32'd0);
    rd("minstret_3", 12'hB02, 32'd3);

    // CSR writes: mtvec, mstatus, then ecall
    send(0, 0, 0, T_CSRRW, 12'h305, 32'h8000_0100, 0, 0, 32'h8000_000C);
    tick();
    check("csrfwd_valid", {31'b0, ws_csr_fwd_valid_o}, 32'd1);
    check("csrfwd_addr", {20'b0, ws_csr_fwd_addr_o}, 32'h305);
    check("csrfwd_data", ws_csr_fwd_data_o, 32'h8000_0100);
    check("mtvec_before_commit", mtvec_o, 32'h0);
    send(0, 0, 0, T_CSRRW, 12'h300, 32'h0000_0088, 0, 0, 32'h8000_0010);
    tick();
    check("mtvec_commit", mtvec_o, 32'h8000_0100);
    send(0, 0, 0, T_ECALL, 0, 0, 32'd11, 0, 32'h8000_0040);
    tick();
    check("ecall_no_csrfwd", {31'b0, ws_csr_fwd_valid_o}, 32'd0);
    rd("mstatus_wr", 12'h300, 32'h0000_0088);
    idle();
    tick();
    check("ecall_mepc", mepc_o, 32'h8000_0040);
    rd("ecall_mcause", 12'h342, 32'h0000_000B);
    rd("ecall_mepc_rd", 12'h341, 32'h8000_0040);
    rd("minstret_6", 12'hB02, 32'd6);

    // Counter wrap: write mcycle lo = all ones, carry appears a cycle later
    send(0, 0, 0, T_CSRRW, 12'hB00, 32'hFFFF_FFFF, 0, 0, 32'h8000_0044);
    tick();
    idle();
    tick();
    rd("mcycle_lo_wr", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_hi_pre", 12'hB80, 32'h0);
    tick();
    rd("mcycle_lo_wrap", 12'hB00, 32'h0);
    rd("mcycle_hi_carry", 12'hB80, 32'h1);

    // Write minstret lo while the same instruction retires: written value wins
    send(0, 0, 0, T_CSRRW, 12'hB02, 32'h0000_0100, 0, 0, 32'h8000_0048);
    tick();
    idle();
    tick();
    rd("minstret_wr_prio", 12'hB02, 32'h0000_0100);

    // ebreak halt: preset mcycle lo, then ebreak, then another instruction
    send(0, 0, 0, T_CSRRW, 12'hB00, 32'h0000_1000, 0, 0, 32'h8000_004C);
    tick();
    send(1, 5'd7, 32'h77, T_NONE, 0, 0, 0, 1, 32'h8000_0050);
    tick();
    check("ebreak_retire", {31'b0, retire_o}, 32'd1);
    check("ebreak_we", {31'b0, rf_we_o}, 32'd1);
    check("ebreak_halt_pre", {31'b0, halt_o}, 32'd0);
    send(1, 5'd8, 32'h88, T_NONE, 0, 0, 0, 0, 32'h8000_0054);
    tick();
    check("halt_on", {31'b0, halt_o}, 32'd1);
    check("halt_allowin", {31'b0, wbu_allowin_o}, 32'd0);
    check("halt_no_capture", {31'b0, ws_fwd_valid_o}, 32'd0);
    check("halt_no_retire", {31'b0, retire_o}, 32'd0);
    rd("halt_mcycle", 12'hB00, 32'h0000_1001);
    rd("halt_minstret", 12'hB02, 32'h0000_0102);
    repeat (3) tick();
    check("halt_hold_we", {31'b0, rf_we_o}, 32'd0);
    check("halt_hold_fwd", {31'b0, ws_fwd_valid_o}, 32'd0);
    rd("halt_mcycle_frozen", 12'hB00, 32'h0000_1001);

    // Asynchronous reset while halted, between edges
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("areset_halt", {31'b0, halt_o}, 32'd0);
    check("areset_mtvec", mtvec_o, 32'h0);
    check("areset_mepc", mepc_o, 32'h0);
    rd("areset_mstatus", 12'h300, 32'h0000_1800);
    rd("areset_mcycle_hi", 12'hB80, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("areset_allowin", {31'b0, wbu_allowin_o}, 32'd1);

    // Asynchronous reset while an instruction is held: no GPR or CSR write
    send(1, 5'd9, 32'h99, T_CSRRW, 12'h305, 32'h0000_1234, 0, 0, 32'h8000_0060);
    tick();
    check("mid_we_before", {31'b0, rf_we_o}, 32'd1);
    #2;
    reset = 1'b1;
    idle();
    #1;
    check("mid_we_drop", {31'b0, rf_we_o}, 32'd0);
    check("mid_retire_drop", {31'b0, retire_o}, 32'd0);
    check("mid_fwd_drop", {31'b0, ws_fwd_valid_o}, 32'd0);
    check("mid_csrfwd_drop", {31'b0, ws_csr_fwd_valid_o}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_mtvec", mtvec_o, 32'h0);
    rd("mid_minstret", 12'hB02, 32'h0);
    check("mid_we_after", {31'b0, rf_we_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
